// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift-register sequencer: transmit FSM state
// encoding, loopback latency and loopback-check queue sizing.
package shift_seq_pkg;

  // Transmit FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAPW = 2'd2
  } state_e;

  // Cycles between driving a bit on sr_si and seeing it on sr_so: one per
  // stage of the external serial-in/serial-out register.
  function automatic int lat_cycles(input int width);
    return width;
  endfunction

  // Words that can be outstanding between leaving the transmitter and
  // being checked at the receiver, given the word period WIDTH+GAP.
  function automatic int queue_depth(input int width, input int gap);
    return (2 * width + gap + (width + gap) - 1) / (width + gap);
  endfunction

endpackage

// File: rtl/shift_seq_rx.sv
// Receive path: tracks which sr_so samples carry real bits through a
// valid/start-marker delay line matched to the shift register latency,
// counts bits and deserialises each word LSB first.
module shift_seq_rx
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_valid_i,
  input  logic             bit_start_i,
  input  logic             sr_so_i,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             inflight_o
);

  localparam int LAT = lat_cycles(WIDTH);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             dl_valid_q [LAT];
  logic             dl_start_q [LAT];
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic             sample;
  logic             start;
  logic [CNT_W-1:0] bit_pos;
  logic             inflight_d;

  genvar gi;
  generate
    for (gi = 0; gi < LAT; gi++) begin : g_dl
      logic v_in;
      logic s_in;
      if (gi == 0) begin : g_head
        assign v_in = bit_valid_i;
        assign s_in = bit_start_i;
      end else begin : g_tail
        assign v_in = dl_valid_q[gi-1];
        assign s_in = dl_start_q[gi-1];
      end
      // One delay-line stage; cleared on reset so aborted bits are forgotten.
      always_ff @(posedge clk) begin
        if (rst) begin
          dl_valid_q[gi] <= 1'b0;
          dl_start_q[gi] <= 1'b0;
        end else begin
          dl_valid_q[gi] <= v_in;
          dl_start_q[gi] <= s_in;
        end
      end
    end
  endgenerate

  assign sample  = dl_valid_q[LAT-1];
  assign start   = dl_start_q[LAT-1];
  // The start marker resynchronises the bit counter on every word.
  assign bit_pos = start ? '0 : cnt_q;
  assign shift_d = {sr_so_i, shift_q[WIDTH-1:1]};

  // Any tracked bit still travelling through the external register.
  always_comb begin
    inflight_d = 1'b0;
    for (int i = 0; i < LAT; i++) begin
      inflight_d = inflight_d | dl_valid_q[i];
    end
  end

  // Deserialise sampled bits and publish the word after its last bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (sample) begin
        shift_q <= shift_d;
        if (bit_pos == CNT_LAST) begin
          out_valid_q <= 1'b1;
          out_data_q  <= shift_d;
          cnt_q       <= '0;
        end else begin
          cnt_q <= bit_pos + 1'b1;
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;
  assign inflight_o  = inflight_d;

endmodule

// File: rtl/shift_seq_ctrl.sv
// Shift-register sequencer: serialises parallel words onto sr_si LSB first,
// receives them back from sr_so after the register latency and reports them
// on out_valid/out_data. Optional macro SHIFT_SEQ_LOOPBACK_CHECK_EN adds a
// queue of sent words and a sticky compare error on mismatch_err.
module shift_seq_ctrl
  import shift_seq_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int GAP   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             sr_si,
  input  logic             sr_so,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             busy,
  output logic             mismatch_err
);

  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WIDTH - 1);
  localparam logic [3:0] GAP_LAST = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
  localparam int WARM_W = $clog2(WIDTH + 2);
  localparam logic [WARM_W-1:0] WARM_INIT = WARM_W'(WIDTH + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic [3:0]         gap_cnt_q, gap_cnt_d;
  logic [WARM_W-1:0]  warm_q;
  logic               accept;
  logic               last_bit;
  logic               tx_bit_valid;
  logic               tx_bit_start;
  logic               rx_inflight;

  assign last_bit = (state_q == SEND) && (bit_idx_q == IDX_LAST);
  assign in_ready = !rst && (warm_q == '0) &&
                    ((state_q == IDLE) || ((GAP == 0) && last_bit));
  assign accept   = in_valid && in_ready;

  // Transmit FSM next-state: a new word can chain straight onto the last
  // bit only when no idle gap is configured.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    word_d    = word_q;
    gap_cnt_d = gap_cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SEND;
          bit_idx_d = '0;
          word_d    = in_data;
        end
      end
      SEND: begin
        if (last_bit) begin
          if (GAP > 0) begin
            state_d   = GAPW;
            gap_cnt_d = '0;
          end else if (accept) begin
            bit_idx_d = '0;
            word_d    = in_data;
          end else begin
            state_d = IDLE;
          end
        end else begin
          bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      GAPW: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Transmit FSM registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      bit_idx_q <= '0;
      word_q    <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_idx_q <= bit_idx_d;
      word_q    <= word_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Warm-up: the external register holds stale bits after reset, so hold
  // off accepting until it has been flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      warm_q <= WARM_INIT;
    end else if (warm_q != '0) begin
      warm_q <= warm_q - 1'b1;
    end
  end

  assign sr_si        = !rst && (state_q == SEND) && word_q[bit_idx_q];
  assign tx_bit_valid = (state_q == SEND);
  assign tx_bit_start = (state_q == SEND) && (bit_idx_q == '0);

  shift_seq_rx #(
    .WIDTH(WIDTH)
  ) u_rx (
    .clk        (clk),
    .rst        (rst),
    .bit_valid_i(tx_bit_valid),
    .bit_start_i(tx_bit_start),
    .sr_so_i    (sr_so),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .inflight_o (rx_inflight)
  );

  // GAPW is not counted: no untracked bit exists once the last bit left.
  assign busy = !rst && (accept || (state_q == SEND) || rx_inflight || out_valid);

`ifdef SHIFT_SEQ_LOOPBACK_CHECK_EN
  localparam int QD = queue_depth(WIDTH, GAP);
  localparam int QP_W = (QD > 1) ? $clog2(QD) : 1;
  localparam logic [QP_W-1:0] QP_LAST = QP_W'(QD - 1);

  logic [WIDTH-1:0] q_mem [QD];
  logic [QP_W-1:0]  wr_ptr_q;
  logic [QP_W-1:0]  rd_ptr_q;
  logic             mismatch_q;
  logic             q_push;
  logic             q_pop;

  // Words are queued once fully transmitted rather than at accept; an
  // aborted word never enters and the queue never exceeds QD entries.
  assign q_push = last_bit;
  assign q_pop  = out_valid;

  // Queue storage; contents need no reset since pointers gate them.
  always_ff @(posedge clk) begin
    if (q_push) begin
      q_mem[wr_ptr_q] <= word_q;
    end
  end

  // Queue pointers and sticky compare error.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mismatch_q <= 1'b0;
    end else begin
      if (q_push) begin
        wr_ptr_q <= (wr_ptr_q == QP_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (q_pop) begin
        rd_ptr_q <= (rd_ptr_q == QP_LAST) ? '0 : rd_ptr_q + 1'b1;
        if (out_data != q_mem[rd_ptr_q]) begin
          mismatch_q <= 1'b1;
        end
      end
    end
  end

  assign mismatch_err = mismatch_q;
`else
  assign mismatch_err = 1'b0;
`endif

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Directed bench for shift_seq_ctrl: two instances (GAP=0 and GAP=2), each
// looped back through a 4-deep shift register model; per-cycle outputs are
// logged and compared against hand-computed values.
module tb_shift_seq_ctrl;

`ifdef SHIFT_SEQ_LOOPBACK_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic clk;
  logic rst;

  logic       iv0, ir0, si0, so0, ov0, busy0, err0, flip0;
  logic [3:0] id0, od0, sr0;
  logic       iv2, ir2, si2, so2, ov2, busy2, err2;
  logic [3:0] id2, od2, sr2;

  logic [3:0] q0 [$];
  logic [3:0] q2 [$];

  logic [63:0] lr0, ls0, lov0, lb0, le0;
  logic [3:0]  lod0 [64];
  logic [63:0] lr2, ls2, lov2;
  logic [3:0]  lod2 [64];

  int errors = 0;
  int checks = 0;

  shift_seq_ctrl #(.WIDTH(4), .GAP(0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_data(id0), .in_ready(ir0),
    .sr_si(si0), .sr_so(so0), .out_valid(ov0), .out_data(od0),
    .busy(busy0), .mismatch_err(err0)
  );

  shift_seq_ctrl #(.WIDTH(4), .GAP(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_data(id2), .in_ready(ir2),
    .sr_si(si2), .sr_so(so2), .out_valid(ov2), .out_data(od2),
    .busy(busy2), .mismatch_err(err2)
  );

  // External SISO register models (never reset); flip0 corrupts one bit.
  always @(posedge clk) begin
    sr0 <= {sr0[2:0], si0 ^ flip0};
    sr2 <= {sr2[2:0], si2};
  end
  assign so0 = sr0[3];
  assign so2 = sr2[3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int count_ov(input logic [63:0] v, input int lo, input int hi);
    int n = 0;
    for (int i = lo; i <= hi; i++) if (v[i]) n++;
    return n;
  endfunction

  // Hold reset two cycles and check the in-reset output values of dut0.
  task automatic do_reset();
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      rst = 1'b1; iv0 = 1'b0; iv2 = 1'b0; flip0 = 1'b0;
      @(negedge clk);
    end
    chk("rst_in_ready", 32'(ir0), 32'd0);
    chk("rst_sr_si", 32'(si0), 32'd0);
    chk("rst_out_valid", 32'(ov0), 32'd0);
    chk("rst_out_data", 32'(od0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_mismatch", 32'(err0), 32'd0);
  endtask

  // Cycle 0 is the first cycle with rst low; rst_cyc/flip_cyc <0 disable.
  task automatic run(input int ncyc, input int rst_cyc, input int flip_cyc);
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      rst   = (c == rst_cyc);
      flip0 = (c == flip_cyc);
      iv0 = (q0.size() > 0);
      id0 = iv0 ? q0[0] : 4'h0;
      iv2 = (q2.size() > 0);
      id2 = iv2 ? q2[0] : 4'h0;
      @(negedge clk);
      lr0[c] = ir0; ls0[c] = si0; lov0[c] = ov0; lb0[c] = busy0; le0[c] = err0;
      lod0[c] = od0;
      lr2[c] = ir2; ls2[c] = si2; lov2[c] = ov2; lod2[c] = od2;
      if (iv0 && ir0) begin
        $display("dut0 cycle %0d accept %h", c, id0);
        q0.delete(0);
      end
      if (iv2 && ir2) begin
        $display("dut2 cycle %0d accept %h", c, id2);
        q2.delete(0);
      end
      if (ov0) $display("dut0 cycle %0d out_data %h", c, od0);
      if (ov2) $display("dut2 cycle %0d out_data %h", c, od2);
    end
  endtask

  initial begin
    rst = 1'b1; iv0 = 1'b0; id0 = 4'h0; iv2 = 1'b0; id2 = 4'h0; flip0 = 1'b0;

    // Single word 4'hA with in_valid held from reset release (warm-up).
    do_reset();
    q0.push_back(4'hA);
    run(24, -1, -1);
    chk("A_warmup_ready", 32'(lr0[4:0]), 32'd0);
    chk("A_first_ready", 32'(lr0[5]), 32'd1);
    chk("A_si_bits", 32'(ls0[9:6]), 32'hA);
    chk("A_ov_count", 32'(count_ov(lov0, 0, 23)), 32'd1);
    chk("A_ov_at14", 32'(lov0[14]), 32'd1);
    chk("A_data", 32'(lod0[14]), 32'hA);
    chk("A_data_hold", 32'(lod0[20]), 32'hA);
    chk("A_busy_accept", 32'(lb0[5]), 32'd1);
    chk("A_busy_ov", 32'(lb0[14]), 32'd1);
    chk("A_busy_done", 32'(lb0[15]), 32'd0);
    chk("A_mismatch", 32'(le0[20]), 32'd0);

    // Back-to-back 1, F, 6 with no bubble.
    do_reset();
    q0.push_back(4'h1); q0.push_back(4'hF); q0.push_back(4'h6);
    run(30, -1, -1);
    chk("B_ready5", 32'(lr0[5]), 32'd1);
    chk("B_ready_low", 32'(lr0[8:6]), 32'd0);
    chk("B_ready9", 32'(lr0[9]), 32'd1);
    chk("B_ready13", 32'(lr0[13]), 32'd1);
    chk("B_si_stream", 32'(ls0[17:6]), 32'h6F1);
    chk("B_ov_count", 32'(count_ov(lov0, 0, 29)), 32'd3);
    chk("B_ov14", 32'(lov0[14]), 32'd1);
    chk("B_data1", 32'(lod0[14]), 32'h1);
    chk("B_ov18", 32'(lov0[18]), 32'd1);
    chk("B_dataF", 32'(lod0[18]), 32'hF);
    chk("B_ov22", 32'(lov0[22]), 32'd1);
    chk("B_data6", 32'(lod0[22]), 32'h6);
    chk("B_busy22", 32'(lb0[22]), 32'd1);
    chk("B_busy23", 32'(lb0[23]), 32'd0);
    chk("B_mismatch", 32'(le0[29]), 32'd0);

    // Reset pulse two bits into 4'h9, then 4'h5.
    do_reset();
    q0.push_back(4'h9); q0.push_back(4'h5);
    run(30, 8, -1);
    chk("C_no_ov9", 32'(count_ov(lov0, 0, 22)), 32'd0);
    chk("C_busy_after_rst", 32'(lb0[9]), 32'd0);
    chk("C_data_cleared", 32'(lod0[9]), 32'd0);
    chk("C_rewarm", 32'(lr0[13:9]), 32'd0);
    chk("C_ready14", 32'(lr0[14]), 32'd1);
    chk("C_ov23", 32'(lov0[23]), 32'd1);
    chk("C_data5", 32'(lod0[23]), 32'h5);
    chk("C_mismatch", 32'(le0[29]), 32'd0);

    // Corrupt bit 0 of word 4'h0 in the loopback.
    do_reset();
    q0.push_back(4'h0);
    run(30, -1, 6);
    chk("D_ov14", 32'(lov0[14]), 32'd1);
    chk("D_data", 32'(lod0[14]), 32'h1);
    chk("D_err_at_ov", 32'(le0[14]), 32'd0);
    chk("D_err_next", 32'(le0[15]), 32'(EXP_ERR));
    chk("D_err_sticky", 32'(le0[29]), 32'(EXP_ERR));
    do_reset();

    // GAP=2 instance: 3 then C with idle cycles between.
    q2.push_back(4'h3); q2.push_back(4'hC);
    run(30, -1, -1);
    chk("E_ready5", 32'(lr2[5]), 32'd1);
    chk("E_no_chain", 32'(lr2[9]), 32'd0);
    chk("E_ready12", 32'(lr2[12]), 32'd1);
    chk("E_si_w3", 32'(ls2[9:6]), 32'h3);
    chk("E_si_gap", 32'(ls2[11:10]), 32'd0);
    chk("E_si_wC", 32'(ls2[16:13]), 32'hC);
    chk("E_ov14", 32'(lov2[14]), 32'd1);
    chk("E_data3", 32'(lod2[14]), 32'h3);
    chk("E_ov21", 32'(lov2[21]), 32'd1);
    chk("E_dataC", 32'(lod2[21]), 32'hC);
    chk("E_ov_count", 32'(count_ov(lov2, 0, 29)), 32'd2);
    chk("E_dut0_idle", 32'(count_ov(lov0, 0, 29)), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
